wishbone_nn_stream_bridge: RTL and testbench
============================================

// Module: wishbone_nn_stream_bridge
// PURPOSE
//  Parametrised Wishbone slave bridging the Caravel bus to the NN core via two FIFOs:
//  host->core input FIFO (bus writes push) and core->host output FIFO (bus reads pop).
//  Adds registered single-pulse ack, STATUS/CTRL registers, sticky over/underflow flags,
//  flush, and valid/ready stream ports toward the NN datapath.
// PARAMETERS
//  BASE_ADDR  32'h3000_0000  byte address of DATA reg; STATUS=+4, CTRL=+8
//  DATA_W     32             FIFO word width, 1..32; bus bits above DATA_W ignored/read 0
//  IN_DEPTH   16             input FIFO depth, power of 2, 2..128
//  OUT_DEPTH  16             output FIFO depth, power of 2, 2..128
// PORTS
//  wb_clk_i     in   1       single clock, all logic rising edge
//  wb_rst_i     in   1       asynchronous, active-low reset
//  wbs_stb_i    in   1       strobe
//  wbs_cyc_i    in   1       cycle
//  wbs_we_i     in   1       1=write
//  wbs_sel_i    in   4       byte selects, ignored (full-word access only)
//  wbs_adr_i    in   32      byte address
//  wbs_dat_i    in   32      write data
//  wbs_ack_o    out  1       registered ack
//  wbs_dat_o    out  32      registered read data
//  in_valid_o   out  1       input FIFO non-empty
//  in_data_o    out  DATA_W  input FIFO head (first-word fall-through)
//  in_ready_i   in   1       core pops input head when valid&ready
//  out_valid_i  in   1       core offers result word
//  out_data_i   in   DATA_W  result word
//  out_ready_o  out  1       = !out_full; push when valid&ready
// BEHAVIOUR
//  Reset (wb_rst_i=0): ack, dat_o, in_valid_o, out_ready_o=0; pointers/counts/sticky=0.
//  Accept: cycle where stb&cyc&!ack_q&addr in {BASE,+4,+8}; ack_q=1 next cycle, exactly one
//   cycle; wbs_dat_o valid only in ack cycle, 0 otherwise. Unmapped addr: never acked.
//  Write DATA: push wbs_dat_i[DATA_W-1:0] if in FIFO not full; else drop, set OVF. Acked.
//  Read DATA: if out FIFO non-empty return head zero-extended, pop; else return 0, set UDF.
//  STATUS (read-only, writes acked/ignored): [0]in_empty [1]in_full [2]out_empty
//   [3]out_full [4]OVF [5]UDF [15:8]in_count [23:16]out_count, rest 0. Values sampled at accept.
//  CTRL (write; read returns 0): [0] flush input FIFO, [1] flush output FIFO, [2] clear OVF/UDF.
//  Full/empty judged on state at start of cycle: push to full FIFO dropped even if pop same
//   cycle; simultaneous push+pop on non-full non-empty FIFO keeps count unchanged.
//  Flush wins over any same-cycle push/pop on that FIFO (stream word discarded, count->0).
//  Pointers log2(DEPTH) bits, wrap naturally; count log2(DEPTH)+1 bits, 0..DEPTH.
//  Reset mid-transaction: ack drops at once; master retries; FIFO contents lost.
// STRUCTURE
//  Package wishbone_nn_pkg: DATA/STATUS/CTRL offsets, STATUS/CTRL bit indices.
//  Sub-module nn_sync_fifo #(WIDTH,DEPTH): FWFT, push/pop/flush, full/empty/count;
//   instantiated twice. Top holds decode, ack/dat_o regs, sticky flags.
// TESTING
//  Reset then read STATUS -> 32'h0000_0005 (both empty), ack one cycle after stb.
//  Write 1..16 to DATA (IN_DEPTH=16), in_ready_i=0 -> STATUS in_full=1, in_count=16;
//   17th write acked, dropped, OVF=1; in_ready_i=1 drains 1..16 in order.
//  Core pushes 32'hA5A5_0001,0002 -> two DATA reads return them, third returns 0 and sets UDF.
//  in_ready_i=1 while host streams writes -> push+pop same cycle, count stays constant, no loss.
//  Write CTRL=3 with both FIFOs part-full -> both counts 0; CTRL=4 clears OVF/UDF.
//  Access BASE+12 -> no ack within 16 cycles; hold stb across ack -> exactly one ack per accept.

Source files
------------

// File: rtl/wishbone_nn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wishbone_nn_pkg
//  Description : Register offsets and STATUS/CTRL bit positions for the
//                Wishbone <-> NN stream bridge.
//  Revision    : 1.0 - initial release
// ============================================================================
package wishbone_nn_pkg;

    // Byte offsets from BASE_ADDR
    localparam logic [31:0] c_off_data   = 32'h0000_0000;
    localparam logic [31:0] c_off_status = 32'h0000_0004;
    localparam logic [31:0] c_off_ctrl   = 32'h0000_0008;

    // STATUS bit positions
    localparam int c_st_in_empty  = 0;
    localparam int c_st_in_full   = 1;
    localparam int c_st_out_empty = 2;
    localparam int c_st_out_full  = 3;
    localparam int c_st_ovf       = 4;
    localparam int c_st_udf       = 5;
    localparam int c_st_in_cnt_lo = 8;
    localparam int c_st_out_cnt_lo = 16;

    // CTRL bit positions
    localparam int c_ctrl_flush_in  = 0;
    localparam int c_ctrl_flush_out = 1;
    localparam int c_ctrl_clr_flags = 2;

endpackage
`default_nettype wire

// File: rtl/nn_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : nn_sync_fifo
//  Description : Single-clock first-word-fall-through FIFO with flush.
//                Full/empty are judged on the state at the start of the
//                cycle; flush overrides any same-cycle push or pop.
//  Revision    : 1.0 - initial release
// ============================================================================
module nn_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic [WIDTH-1:0]         o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic w_full;
    logic w_empty;
    logic w_do_push;
    logic w_do_pop;

    assign w_full    = (r_count == (AW+1)'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_do_push = i_push & ~w_full  & ~i_flush;
    assign w_do_pop  = i_pop  & ~w_empty & ~i_flush;

    // Pointer and occupancy bookkeeping; flush empties the FIFO outright
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/wishbone_nn_stream_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : wishbone_nn_stream_bridge
//  Description : Wishbone slave exposing DATA/STATUS/CTRL registers that
//                bridge host bus traffic to NN-core valid/ready streams via
//                an input FIFO (bus writes) and an output FIFO (bus reads).
//  Revision    : 1.0 - initial release
// ============================================================================
module wishbone_nn_stream_bridge
    import wishbone_nn_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          DATA_W    = 32,
    parameter int          IN_DEPTH  = 16,
    parameter int          OUT_DEPTH = 16
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    output logic              in_valid_o,
    output logic [DATA_W-1:0] in_data_o,
    input  logic              in_ready_i,
    input  logic              out_valid_i,
    input  logic [DATA_W-1:0] out_data_i,
    output logic              out_ready_o
);

    localparam int IN_AW  = $clog2(IN_DEPTH);
    localparam int OUT_AW = $clog2(OUT_DEPTH);

    logic              r_ack;
    logic [31:0]       r_dat;
    logic              r_ovf;
    logic              r_udf;

    logic              w_sel_data;
    logic              w_sel_status;
    logic              w_sel_ctrl;
    logic              w_accept;
    logic              w_wr;
    logic              w_rd;
    logic              w_in_push;
    logic              w_out_pop;
    logic              w_in_flush;
    logic              w_out_flush;
    logic              w_clr_flags;
    logic              w_in_full;
    logic              w_in_empty;
    logic              w_out_full;
    logic              w_out_empty;
    logic [IN_AW:0]    w_in_count;
    logic [OUT_AW:0]   w_out_count;
    logic [DATA_W-1:0] w_out_head;
    logic [31:0]       w_status;
    logic [31:0]       w_rdata;
    logic              w_unused;

    // Byte selects and unused upper write-data bits carry no meaning here
    assign w_unused = ^{wbs_sel_i, wbs_dat_i};

    assign w_sel_data   = (wbs_adr_i == BASE_ADDR + c_off_data);
    assign w_sel_status = (wbs_adr_i == BASE_ADDR + c_off_status);
    assign w_sel_ctrl   = (wbs_adr_i == BASE_ADDR + c_off_ctrl);

    // The !r_ack term turns a held strobe into one ack per accept
    assign w_accept = wbs_stb_i & wbs_cyc_i & ~r_ack &
                      (w_sel_data | w_sel_status | w_sel_ctrl);
    assign w_wr     = w_accept &  wbs_we_i;
    assign w_rd     = w_accept & ~wbs_we_i;

    assign w_in_push   = w_wr & w_sel_data;
    assign w_out_pop   = w_rd & w_sel_data;
    assign w_in_flush  = w_wr & w_sel_ctrl & wbs_dat_i[c_ctrl_flush_in];
    assign w_out_flush = w_wr & w_sel_ctrl & wbs_dat_i[c_ctrl_flush_out];
    assign w_clr_flags = w_wr & w_sel_ctrl & wbs_dat_i[c_ctrl_clr_flags];

    nn_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (IN_DEPTH)
    ) u_in_fifo (
        .clk         (wb_clk_i),
        .rst_n       (wb_rst_i),
        .i_push      (w_in_push),
        .i_push_data (wbs_dat_i[DATA_W-1:0]),
        .i_pop       (in_ready_i),
        .i_flush     (w_in_flush),
        .o_head      (in_data_o),
        .o_full      (w_in_full),
        .o_empty     (w_in_empty),
        .o_count     (w_in_count)
    );

    nn_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (OUT_DEPTH)
    ) u_out_fifo (
        .clk         (wb_clk_i),
        .rst_n       (wb_rst_i),
        .i_push      (out_valid_i),
        .i_push_data (out_data_i),
        .i_pop       (w_out_pop),
        .i_flush     (w_out_flush),
        .o_head      (w_out_head),
        .o_full      (w_out_full),
        .o_empty     (w_out_empty),
        .o_count     (w_out_count)
    );

    assign in_valid_o  = ~w_in_empty;
    // Held low while reset is asserted so the core never pushes into reset
    assign out_ready_o = wb_rst_i & ~w_out_full;

    // STATUS word assembled from live FIFO state and sticky flags
    always_comb begin
        w_status = '0;
        w_status[c_st_in_empty]  = w_in_empty;
        w_status[c_st_in_full]   = w_in_full;
        w_status[c_st_out_empty] = w_out_empty;
        w_status[c_st_out_full]  = w_out_full;
        w_status[c_st_ovf]       = r_ovf;
        w_status[c_st_udf]       = r_udf;
        w_status[c_st_in_cnt_lo  +: 8] = 8'(w_in_count);
        w_status[c_st_out_cnt_lo +: 8] = 8'(w_out_count);
    end

    // Read-data mux; CTRL and empty DATA reads return zero
    always_comb begin
        w_rdata = '0;
        if (w_sel_data && !w_out_empty) begin
            w_rdata[DATA_W-1:0] = w_out_head;
        end else if (w_sel_status) begin
            w_rdata = w_status;
        end
    end

    // Single-cycle ack and read data, data forced to zero outside ack
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            r_ack <= 1'b0;
            r_dat <= '0;
        end else begin
            r_ack <= w_accept;
            r_dat <= w_rd ? w_rdata : '0;
        end
    end

    // Sticky overflow/underflow flags, cleared only through CTRL
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else if (w_clr_flags) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            if (w_in_push && w_in_full)    r_ovf <= 1'b1;
            if (w_out_pop && w_out_empty)  r_udf <= 1'b1;
        end
    end

    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_dat;

endmodule
`default_nettype wire

// File: tb/tb_wishbone_nn_stream_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wishbone_nn_stream_bridge
//  Description : Directed self-checking bench for the Wishbone NN bridge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wishbone_nn_stream_bridge;

    localparam logic [31:0] c_base   = 32'h3000_0000;
    localparam logic [31:0] c_data   = c_base;
    localparam logic [31:0] c_status = c_base + 32'd4;
    localparam logic [31:0] c_ctrl   = c_base + 32'd8;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        in_valid_o;
    logic [31:0] in_data_o;
    logic        in_ready_i;
    logic        out_valid_i;
    logic [31:0] out_data_i;
    logic        out_ready_o;

    int n_checks = 0;
    int n_errors = 0;

    wishbone_nn_stream_bridge #(
        .BASE_ADDR (c_base),
        .DATA_W    (32),
        .IN_DEPTH  (16),
        .OUT_DEPTH (16)
    ) u_dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_i    (wb_rst_i),
        .wbs_stb_i   (wbs_stb_i),
        .wbs_cyc_i   (wbs_cyc_i),
        .wbs_we_i    (wbs_we_i),
        .wbs_sel_i   (wbs_sel_i),
        .wbs_adr_i   (wbs_adr_i),
        .wbs_dat_i   (wbs_dat_i),
        .wbs_ack_o   (wbs_ack_o),
        .wbs_dat_o   (wbs_dat_o),
        .in_valid_o  (in_valid_o),
        .in_data_o   (in_data_o),
        .in_ready_i  (in_ready_i),
        .out_valid_i (out_valid_i),
        .out_data_i  (out_data_i),
        .out_ready_o (out_ready_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One bus transfer; returns ack latency in cycles (0 = no ack within 16)
    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                           output logic [31:0] rd, output int lat);
        wbs_stb_i = 1'b1;
        wbs_cyc_i = 1'b1;
        wbs_we_i  = we;
        wbs_adr_i = adr;
        wbs_dat_i = wd;
        lat = 0;
        rd  = '0;
        for (int i = 1; i <= 16; i++) begin
            @(posedge wb_clk_i); #1;
            if (wbs_ack_o) begin
                lat = i;
                rd  = wbs_dat_o;
                break;
            end
        end
        wbs_stb_i = 1'b0;
        wbs_cyc_i = 1'b0;
        wbs_we_i  = 1'b0;
        @(posedge wb_clk_i); #1;
        if (lat != 0) begin
            check_val("ack_single", {31'd0, wbs_ack_o}, 32'd0);
            check_val("dat_idle_zero", wbs_dat_o, 32'd0);
        end
    endtask

    task automatic wb_write(input string tag, input logic [31:0] adr, input logic [31:0] wd);
        logic [31:0] rd;
        int lat;
        wb_xfer(1'b1, adr, wd, rd, lat);
        check_val(tag, lat, 32'd1);
    endtask

    task automatic wb_read_chk(input string tag, input logic [31:0] adr, input logic [31:0] exp);
        logic [31:0] rd;
        int lat;
        wb_xfer(1'b0, adr, 32'd0, rd, lat);
        check_val({tag, "_lat"}, lat, 32'd1);
        check_val(tag, rd, exp);
    endtask

    task automatic core_push(input logic [31:0] d);
        out_valid_i = 1'b1;
        out_data_i  = d;
        @(posedge wb_clk_i); #1;
        out_valid_i = 1'b0;
        out_data_i  = '0;
    endtask

    initial begin
        logic [31:0] rd;
        int lat;
        int acks;

        wb_rst_i    = 1'b0;
        wbs_stb_i   = 1'b0;
        wbs_cyc_i   = 1'b0;
        wbs_we_i    = 1'b0;
        wbs_sel_i   = 4'hF;
        wbs_adr_i   = '0;
        wbs_dat_i   = '0;
        in_ready_i  = 1'b0;
        out_valid_i = 1'b0;
        out_data_i  = '0;

        // Reset state
        repeat (3) @(posedge wb_clk_i);
        #1;
        check_val("rst_ack",       {31'd0, wbs_ack_o},   32'd0);
        check_val("rst_dat",       wbs_dat_o,            32'd0);
        check_val("rst_in_valid",  {31'd0, in_valid_o},  32'd0);
        check_val("rst_out_ready", {31'd0, out_ready_o}, 32'd0);
        wb_rst_i = 1'b1;
        @(posedge wb_clk_i); #1;
        check_val("out_ready_post_rst", {31'd0, out_ready_o}, 32'd1);

        // STATUS after reset: both FIFOs empty
        wb_read_chk("status_reset", c_status, 32'h0000_0005);

        // Fill input FIFO to the brim, then overflow once
        for (int i = 1; i <= 16; i++) wb_write("fill_wr", c_data, i);
        wb_read_chk("status_in_full", c_status, 32'h0000_1006);
        wb_write("ovf_wr", c_data, 32'd17);
        wb_read_chk("status_ovf", c_status, 32'h0000_1016);

        // Core drains 1..16 in order
        in_ready_i = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            check_val("drain_valid", {31'd0, in_valid_o}, 32'd1);
            check_val("drain_data", in_data_o, i);
            @(posedge wb_clk_i); #1;
        end
        in_ready_i = 1'b0;
        check_val("drain_empty", {31'd0, in_valid_o}, 32'd0);
        wb_read_chk("status_drained", c_status, 32'h0000_0015);
        wb_write("clr_ovf", c_ctrl, 32'd4);
        wb_read_chk("status_clr1", c_status, 32'h0000_0005);

        // Core results read back, then underflow
        core_push(32'hA5A5_0001);
        core_push(32'hA5A5_0002);
        wb_read_chk("rd_res1", c_data, 32'hA5A5_0001);
        wb_read_chk("rd_res2", c_data, 32'hA5A5_0002);
        wb_read_chk("rd_empty", c_data, 32'h0000_0000);
        wb_read_chk("status_udf", c_status, 32'h0000_0025);
        wb_write("clr_udf", c_ctrl, 32'd4);
        wb_read_chk("status_clr2", c_status, 32'h0000_0005);

        // Simultaneous push+pop keeps occupancy constant
        wb_write("pre_wr", c_data, 32'h100);
        wb_write("pre_wr", c_data, 32'h101);
        for (int k = 0; k < 4; k++) begin
            wbs_stb_i  = 1'b1;
            wbs_cyc_i  = 1'b1;
            wbs_we_i   = 1'b1;
            wbs_adr_i  = c_data;
            wbs_dat_i  = 32'h102 + k;
            in_ready_i = 1'b1;
            @(posedge wb_clk_i); #1;
            in_ready_i = 1'b0;
            wbs_stb_i  = 1'b0;
            wbs_cyc_i  = 1'b0;
            wbs_we_i   = 1'b0;
            check_val("stream_ack", {31'd0, wbs_ack_o}, 32'd1);
            check_val("stream_head", in_data_o, 32'h101 + k);
            @(posedge wb_clk_i); #1;
        end
        wb_read_chk("status_stream", c_status, 32'h0000_0204);
        in_ready_i = 1'b1;
        check_val("stream_tail0", in_data_o, 32'h104);
        @(posedge wb_clk_i); #1;
        check_val("stream_tail1", in_data_o, 32'h105);
        @(posedge wb_clk_i); #1;
        in_ready_i = 1'b0;
        check_val("stream_empty", {31'd0, in_valid_o}, 32'd0);

        // Flush both part-full FIFOs
        wb_write("fl_wr", c_data, 32'h11);
        wb_write("fl_wr", c_data, 32'h22);
        wb_write("fl_wr", c_data, 32'h33);
        core_push(32'h44);
        core_push(32'h55);
        wb_read_chk("status_part", c_status, 32'h0002_0300);
        wb_write("flush_both", c_ctrl, 32'd3);
        wb_read_chk("status_flushed", c_status, 32'h0000_0005);
        check_val("flush_in_valid", {31'd0, in_valid_o}, 32'd0);

        // Output FIFO full boundary
        for (int i = 0; i < 16; i++) core_push(32'h200 + i);
        check_val("out_full_ready", {31'd0, out_ready_o}, 32'd0);
        wb_read_chk("status_out_full", c_status, 32'h0010_0009);
        wb_read_chk("out_full_head", c_data, 32'h200);
        check_val("out_ready_again", {31'd0, out_ready_o}, 32'd1);
        wb_write("flush_out", c_ctrl, 32'd2);
        wb_read_chk("status_out_flush", c_status, 32'h0000_0005);

        // Unmapped address is never acknowledged
        wb_xfer(1'b0, c_base + 32'd12, 32'd0, rd, lat);
        check_val("unmapped_noack", lat, 32'd0);

        // Strobe held across acks: one ack per accept, never back-to-back
        acks = 0;
        wbs_stb_i = 1'b1;
        wbs_cyc_i = 1'b1;
        wbs_we_i  = 1'b0;
        wbs_adr_i = c_status;
        for (int i = 0; i < 6; i++) begin
            @(posedge wb_clk_i); #1;
            if (wbs_ack_o) acks++;
            check_val("held_ack_pattern", {31'd0, wbs_ack_o}, (i % 2 == 0) ? 32'd1 : 32'd0);
        end
        wbs_stb_i = 1'b0;
        wbs_cyc_i = 1'b0;
        check_val("held_ack_count", acks, 32'd3);
        @(posedge wb_clk_i); #1;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
